// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// The grant index, valid flag, grant vector and hold counter are all
// registered; the rotating priority search is combinational.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic [1:0]       grant_idx,
    output logic             grant_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [3:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       pick_all;   // {found, index} searching all requests
    logic [2:0]       pick_oth;   // {found, index} searching non-holders only
    logic [3:0]       others;

    // 2-bit index to one-hot select line.
    function automatic logic [3:0] decode(input logic [1:0] idx);
        decode = 4'b0001 << idx;
    endfunction

    // First set bit scanning start, start+1, ... (mod 4). Scanning from the
    // far end backwards lets the closest candidate overwrite the result.
    function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] r);
        logic [1:0] cand;
        pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (r[cand]) pick = {1'b1, cand};
        end
    endfunction

    // Priority searches from the rotate pointer.
    always_comb begin
        others   = req & ~decode(idx_q);
        pick_all = pick(ptr_q, req);
        pick_oth = pick(ptr_q, others);
    end

    // Next-state, pointer, holder and hold-counter logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_all[2]) begin
                    idx_d   = pick_all[1:0];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = pick_all[1:0] + 2'd1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req[idx_q]) begin
                    // Holder released: hand over back-to-back or go idle.
                    if (pick_all[2]) begin
                        idx_d = pick_all[1:0];
                        cnt_d = '0;
                        ptr_d = pick_all[1:0] + 2'd1;
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    // Hold window exhausted: force a switch if anyone waits.
                    if (pick_oth[2]) begin
                        idx_d = pick_oth[1:0];
                        ptr_d = pick_oth[1:0] + 2'd1;
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = valid_d ? decode(idx_d) : 4'b0000;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign hold_cnt    = cnt_q;

endmodule
